// File: rtl/cfu_conv_driver.sv
`timescale 1ns/1ps
// cfu_conv_driver: sequences one CFU convolution run over a cmd/rsp bus:
// INIT, BIAS, OFFS, input writes, kernel writes, COMPUTE, output reads.
// Ports: clk, reset (sync, active-high); start plus cfg_* (captured on start);
// mem_rd_en/mem_addr/mem_rdata source memory port; res_we/res_addr/res_wdata
// result port; cmd_* / rsp_* CFU handshake; busy, done, error status.
module cfu_conv_driver #(
   parameter int ADDR_W      = 16,
   parameter int RSP_TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [31:0]       cfg_bias,
   input  logic [31:0]       cfg_input_offset,
   input  logic [ADDR_W-1:0] cfg_in_base,
   input  logic [ADDR_W-1:0] cfg_k_base,
   input  logic [ADDR_W-1:0] cfg_in_words,
   input  logic [ADDR_W-1:0] cfg_k_words,
   input  logic [ADDR_W-1:0] cfg_out_words,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   output logic              res_we,
   output logic [ADDR_W-1:0] res_addr,
   output logic [31:0]       res_wdata,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [9:0]        cmd_payload_function_id,
   output logic [31:0]       cmd_payload_inputs_0,
   output logic [31:0]       cmd_payload_inputs_1,
   input  logic              rsp_valid,
   output logic              rsp_ready,
   input  logic [31:0]       rsp_payload_outputs_0,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int TW = $clog2(RSP_TIMEOUT + 1);

   typedef enum logic [3:0] {
      IDLE, INIT, BIAS, OFFS, FETCH, WR_IN, WR_K,
      COMPUTE, RD_OUT, WAIT_RSP, DONE
   } state_t;

   state_t            state, state_n;
   // command state that owns the outstanding response (or the pending fetch)
   state_t            cur, cur_n;
   logic [ADDR_W-1:0] idx, idx_n, idx_inc;
   logic [TW-1:0]     wcnt, wcnt_n;
   logic              fetch_ph, fetch_n;
   logic [31:0]       data_q, data_n;
   logic              err_q, err_n;
   logic              go_in, go_k, go_c, go_out;
   logic [6:0]        f7;
   logic [31:0]       idx4;

   logic [31:0]       bias_q, offs_q;
   logic [ADDR_W-1:0] in_base_q, k_base_q;
   logic [ADDR_W-1:0] in_n_q, k_n_q, out_n_q;

   assign idx_inc = idx + ADDR_W'(1);
   assign idx4    = 32'({idx, 2'b00});

   assign cmd_payload_function_id = {f7, 3'b000};
   assign busy  = (state != IDLE);
   assign done  = (state == DONE);
   assign error = err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cur       <= IDLE;
         idx       <= '0;
         wcnt      <= '0;
         fetch_ph  <= 1'b0;
         data_q    <= '0;
         err_q     <= 1'b0;
         bias_q    <= '0;
         offs_q    <= '0;
         in_base_q <= '0;
         k_base_q  <= '0;
         in_n_q    <= '0;
         k_n_q     <= '0;
         out_n_q   <= '0;
      end else begin
         state    <= state_n;
         cur      <= cur_n;
         idx      <= idx_n;
         wcnt     <= wcnt_n;
         fetch_ph <= fetch_n;
         data_q   <= data_n;
         err_q    <= err_n;
         if (state == IDLE && start) begin
            bias_q    <= cfg_bias;
            offs_q    <= cfg_input_offset;
            in_base_q <= cfg_in_base;
            k_base_q  <= cfg_k_base;
            in_n_q    <= cfg_in_words;
            k_n_q     <= cfg_k_words;
            out_n_q   <= cfg_out_words;
         end
      end
   end

   always_comb begin
      state_n   = state;
      cur_n     = cur;
      idx_n     = idx;
      wcnt_n    = wcnt;
      fetch_n   = fetch_ph;
      data_n    = data_q;
      err_n     = err_q;
      go_in     = 1'b0;
      go_k      = 1'b0;
      go_c      = 1'b0;
      go_out    = 1'b0;
      f7        = '0;
      cmd_valid = 1'b0;
      cmd_payload_inputs_0 = '0;
      cmd_payload_inputs_1 = '0;
      rsp_ready = 1'b0;
      mem_rd_en = 1'b0;
      mem_addr  = '0;
      res_we    = 1'b0;
      res_addr  = '0;
      res_wdata = '0;

      unique case (state)
         IDLE: begin
            if (start) begin
               state_n = INIT;
               err_n   = 1'b0;
            end
         end
         INIT, BIAS, OFFS, WR_IN, WR_K, COMPUTE, RD_OUT: begin
            cmd_valid = 1'b1;
            unique case (state)
               BIAS: begin
                  f7 = 7'd7;
                  cmd_payload_inputs_0 = bias_q;
               end
               OFFS: begin
                  f7 = 7'd8;
                  cmd_payload_inputs_0 = offs_q;
               end
               WR_IN: begin
                  f7 = 7'd1;
                  cmd_payload_inputs_0 = idx4;
                  cmd_payload_inputs_1 = data_q;
               end
               WR_K: begin
                  f7 = 7'd2;
                  cmd_payload_inputs_0 = idx4;
                  cmd_payload_inputs_1 = data_q;
               end
               COMPUTE: f7 = 7'd4;
               RD_OUT: begin
                  f7 = 7'd3;
                  cmd_payload_inputs_0 = idx4;
               end
               default: f7 = 7'd0;
            endcase
            if (cmd_ready) begin
               state_n = WAIT_RSP;
               cur_n   = state;
               wcnt_n  = '0;
            end
         end
         FETCH: begin
            // phase 0 strobes the read, phase 1 captures the returned word
            if (!fetch_ph) begin
               mem_rd_en = 1'b1;
               mem_addr  = ((cur == WR_K) ? k_base_q : in_base_q) + idx;
               fetch_n   = 1'b1;
            end else begin
               data_n  = mem_rdata;
               fetch_n = 1'b0;
               state_n = cur;
            end
         end
         WAIT_RSP: begin
            rsp_ready = 1'b1;
            if (rsp_valid) begin
               unique case (cur)
                  INIT: state_n = BIAS;
                  BIAS: state_n = OFFS;
                  OFFS: go_in = 1'b1;
                  WR_IN: begin
                     if (idx_inc == in_n_q) go_k = 1'b1;
                     else begin
                        idx_n   = idx_inc;
                        fetch_n = 1'b0;
                        state_n = FETCH;
                     end
                  end
                  WR_K: begin
                     if (idx_inc == k_n_q) go_c = 1'b1;
                     else begin
                        idx_n   = idx_inc;
                        fetch_n = 1'b0;
                        state_n = FETCH;
                     end
                  end
                  COMPUTE: go_out = 1'b1;
                  RD_OUT: begin
                     res_we    = 1'b1;
                     res_addr  = idx;
                     res_wdata = rsp_payload_outputs_0;
                     if (idx_inc == out_n_q) state_n = DONE;
                     else begin
                        idx_n   = idx_inc;
                        state_n = RD_OUT;
                     end
                  end
                  default: state_n = DONE;
               endcase
            end else if (wcnt == TW'(RSP_TIMEOUT - 1)) begin
               err_n   = 1'b1;
               state_n = DONE;
            end else begin
               wcnt_n = wcnt + TW'(1);
            end
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase

      // phase entry: an empty phase falls straight through to the next
      if (go_in) begin
         if (in_n_q != '0) begin
            idx_n   = '0;
            cur_n   = WR_IN;
            fetch_n = 1'b0;
            state_n = FETCH;
         end else go_k = 1'b1;
      end
      if (go_k) begin
         if (k_n_q != '0) begin
            idx_n   = '0;
            cur_n   = WR_K;
            fetch_n = 1'b0;
            state_n = FETCH;
         end else go_c = 1'b1;
      end
      if (go_c) state_n = COMPUTE;
      if (go_out) begin
         if (out_n_q != '0) begin
            idx_n   = '0;
            state_n = RD_OUT;
         end else state_n = DONE;
      end
   end

endmodule
